// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog reset controller.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WARN      = 2'd1,
    RST_PULSE = 2'd2,
    HOLDOFF   = 2'd3
  } wdt_state_e;

  localparam int unsigned RST_CYCLES_DEF     = 8;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 4;
  localparam int unsigned CNT_W              = 8;

endpackage

// File: rtl/wdt_cycle_counter.sv
// Loadable down-counter that times the reset pulse and the post-reset holdoff.
module wdt_cycle_counter
  import wdt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  // Load has priority over decrement; the count rests at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Two-strike watchdog response: first timeout raises a warning irq, a second
// timeout issues a timed system reset followed by a holdoff window.
module wdt_reset_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = RST_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       timeout,
  input  logic       irq_ack,
  input  logic       cause_clr,
  output logic       wdt_restart,
  output logic       irq,
  output logic       sys_rst,
  output logic       rst_cause,
  output logic [3:0] rst_count
);

  wdt_state_e       state_q, state_d;
  logic             timeout_q;
  logic             timeout_ev;
  logic             enter_rst;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_done;

  logic       irq_q, irq_d;
  logic       sys_rst_q, sys_rst_d;
  logic       wdt_restart_q, wdt_restart_d;
  logic       rst_cause_q, rst_cause_d;
  logic [3:0] rst_count_q, rst_count_d;

  assign timeout_ev = timeout & ~timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout;
    end
  end

  // In WARN, losing enable dominates, and a second timeout beats an ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && timeout_ev) state_d = WARN;
        else                      state_d = IDLE;
      end
      WARN: begin
        if (!enable)         state_d = IDLE;
        else if (timeout_ev) state_d = RST_PULSE;
        else if (irq_ack)    state_d = IDLE;
        else                 state_d = WARN;
      end
      RST_PULSE: begin
        if (cnt_done) state_d = HOLDOFF;
        else          state_d = RST_PULSE;
      end
      HOLDOFF: begin
        if (cnt_done) state_d = IDLE;
        else          state_d = HOLDOFF;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_rst = (state_q == WARN) && (state_d == RST_PULSE);

  always_comb begin
    cnt_load     = enter_rst || ((state_q == RST_PULSE) && cnt_done);
    cnt_load_val = enter_rst ? CNT_W'(RST_CYCLES - 1) : CNT_W'(HOLDOFF_CYCLES - 1);
    cnt_dec      = (state_q == RST_PULSE) || (state_q == HOLDOFF);
  end

  wdt_cycle_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  // Output values are derived from the upcoming state so they register on the transition edge.
  always_comb begin
    irq_d         = (state_d == WARN);
    sys_rst_d     = (state_d == RST_PULSE);
    wdt_restart_d = ((state_q == IDLE) && (state_d == WARN)) ||
                    (state_d == RST_PULSE) || (state_d == HOLDOFF);
    if (enter_rst)      rst_cause_d = 1'b1;
    else if (cause_clr) rst_cause_d = 1'b0;
    else                rst_cause_d = rst_cause_q;
    if (enter_rst && (rst_count_q != 4'd15)) rst_count_d = rst_count_q + 4'd1;
    else                                     rst_count_d = rst_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q         <= 1'b0;
      sys_rst_q     <= 1'b0;
      wdt_restart_q <= 1'b0;
      rst_cause_q   <= 1'b0;
      rst_count_q   <= 4'd0;
    end else begin
      irq_q         <= irq_d;
      sys_rst_q     <= sys_rst_d;
      wdt_restart_q <= wdt_restart_d;
      rst_cause_q   <= rst_cause_d;
      rst_count_q   <= rst_count_d;
    end
  end

  assign irq         = irq_q;
  assign sys_rst     = sys_rst_q;
  assign wdt_restart = wdt_restart_q;
  assign rst_cause   = rst_cause_q;
  assign rst_count   = rst_count_q;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Directed bench for wdt_reset_ctrl with default parameters (8-cycle reset, 4-cycle holdoff).
module tb_wdt_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, timeout, irq_ack, cause_clr;
  logic       wdt_restart, irq, sys_rst, rst_cause;
  logic [3:0] rst_count;

  int vectors = 0;
  int miscompares = 0;
  int n_sys, n_rst;

  always #5 clk = ~clk;

  wdt_reset_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .timeout     (timeout),
    .irq_ack     (irq_ack),
    .cause_clr   (cause_clr),
    .wdt_restart (wdt_restart),
    .irq         (irq),
    .sys_rst     (sys_rst),
    .rst_cause   (rst_cause),
    .rst_count   (rst_count)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Warning, restarted watchdog, second timeout one cycle later, then run out the sequence.
  task automatic full_seq();
    timeout = 1'b1; tick(1);
    timeout = 1'b0; tick(1);
    timeout = 1'b1; tick(1);
    timeout = 1'b0; tick(13);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; timeout = 1'b0; irq_ack = 1'b0; cause_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_irq", 8'(irq), 8'd0);
    chk("rst_sys_rst", 8'(sys_rst), 8'd0);
    chk("rst_restart", 8'(wdt_restart), 8'd0);
    chk("rst_cause0", 8'(rst_cause), 8'd0);
    chk("rst_count0", 8'(rst_count), 8'd0);

    // First strike and acknowledge
    enable = 1'b1; tick(1);
    timeout = 1'b1; tick(1);
    chk("warn_irq", 8'(irq), 8'd1);
    chk("warn_restart_pulse", 8'(wdt_restart), 8'd1);
    tick(1);
    chk("warn_restart_single", 8'(wdt_restart), 8'd0);
    chk("warn_irq_level", 8'(irq), 8'd1);
    tick(1);
    irq_ack = 1'b1; tick(1);
    irq_ack = 1'b0;
    chk("ack_irq_low", 8'(irq), 8'd0);
    chk("ack_no_sysrst", 8'(sys_rst), 8'd0);
    timeout = 1'b0; tick(1);
    chk("ack_idle_restart", 8'(wdt_restart), 8'd0);

    // Second strike 20 cycles after the first, enable dropped mid-pulse
    timeout = 1'b1; tick(1);
    timeout = 1'b0;
    chk("s2_warn_irq", 8'(irq), 8'd1);
    tick(19);
    chk("s2_still_warn", 8'(irq), 8'd1);
    chk("s2_no_sysrst_yet", 8'(sys_rst), 8'd0);
    timeout = 1'b1;
    n_sys = 0; n_rst = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 0) begin
        chk("s2_entry_sysrst", 8'(sys_rst), 8'd1);
        chk("s2_entry_irq", 8'(irq), 8'd0);
        timeout = 1'b0;
      end
      if (i == 2) enable = 1'b0;
      if (i == 6) enable = 1'b1;
      if (sys_rst) n_sys++;
      if (wdt_restart) n_rst++;
    end
    chk("s2_sysrst_len", 8'(n_sys), 8'd8);
    chk("s2_restart_len", 8'(n_rst), 8'd12);
    chk("s2_cause", 8'(rst_cause), 8'd1);
    chk("s2_count", 8'(rst_count), 8'd1);

    // Ack and timeout together in WARN: timeout wins
    timeout = 1'b1; tick(1);
    timeout = 1'b0; tick(1);
    timeout = 1'b1; irq_ack = 1'b1; tick(1);
    timeout = 1'b0; irq_ack = 1'b0;
    chk("tie_sysrst", 8'(sys_rst), 8'd1);
    chk("tie_count", 8'(rst_count), 8'd2);
    tick(12);
    chk("tie_done_restart", 8'(wdt_restart), 8'd0);
    chk("tie_done_sysrst", 8'(sys_rst), 8'd0);

    // Saturation of rst_count
    for (int i = 0; i < 13; i++) full_seq();
    chk("sat_at15", 8'(rst_count), 8'd15);
    for (int i = 0; i < 4; i++) full_seq();
    chk("sat_hold15", 8'(rst_count), 8'd15);

    cause_clr = 1'b1; tick(1);
    cause_clr = 1'b0;
    chk("cause_clr", 8'(rst_cause), 8'd0);
    irq_ack = 1'b1; tick(1);
    irq_ack = 1'b0;
    chk("ack_outside_warn", 8'(irq), 8'd0);
    timeout = 1'b1; tick(1);
    timeout = 1'b0; tick(1);
    timeout = 1'b1; cause_clr = 1'b1; tick(1);
    timeout = 1'b0; cause_clr = 1'b0;
    chk("cause_set_wins", 8'(rst_cause), 8'd1);
    tick(13);

    // rst three cycles into RST_PULSE
    timeout = 1'b1; tick(1);
    timeout = 1'b0; tick(1);
    timeout = 1'b1; tick(1);
    timeout = 1'b0; tick(3);
    chk("abort_pre_sysrst", 8'(sys_rst), 8'd1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    chk("abort_sysrst", 8'(sys_rst), 8'd0);
    chk("abort_restart", 8'(wdt_restart), 8'd0);
    chk("abort_irq", 8'(irq), 8'd0);
    chk("abort_cause", 8'(rst_cause), 8'd0);
    chk("abort_count", 8'(rst_count), 8'd0);
    tick(3);
    chk("abort_idle_restart", 8'(wdt_restart), 8'd0);
    timeout = 1'b1; tick(1);
    chk("post_abort_warn", 8'(irq), 8'd1);

    // enable dropped in WARN, later timeout ignored
    enable = 1'b0; tick(1);
    chk("dis_irq", 8'(irq), 8'd0);
    timeout = 1'b0; tick(1);
    timeout = 1'b1; tick(1);
    chk("dis_ev_irq", 8'(irq), 8'd0);
    chk("dis_ev_restart", 8'(wdt_restart), 8'd0);
    tick(5);
    chk("dis_sysrst", 8'(sys_rst), 8'd0);
    chk("dis_count", 8'(rst_count), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
